// File: rtl/srtsystem_transmitter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// srtsystem_transmitter: 11-bit framed serial transmitter (start, 8 data LSB-first,
// parity, stop) with per-bit clock divider and frame-done pulse.   Rev 1.0
// ----------------------------------------------------------------------------
module srtsystem_transmitter #(
  parameter int BITNUM     = 11,
  parameter int CLKDIV     = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       txclk,
  input  logic       clr,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       TXD,
  output logic       busy,
  output logic       TXF,
  output logic [3:0] extra_counter
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [15:0] DIV_LAST      = 16'(CLKDIV - 1);
  localparam logic [3:0]  LAST_DATA_IDX = 4'(BITNUM - 3);

  state_t      state, state_nx;
  logic [7:0]  data_q, data_nx;
  logic        par_q, par_nx;
  logic [15:0] div_q, div_nx;
  logic [3:0]  cnt_q, cnt_nx;
  logic        txd_q, txd_nx;
  logic        txf_q, txf_nx;
  logic        bit_end;

  assign bit_end = (div_q == DIV_LAST);

  always_ff @(posedge txclk) begin
    if (!clr) begin
      state  <= IDLE;
      data_q <= 8'd0;
      par_q  <= 1'b0;
      div_q  <= 16'd0;
      cnt_q  <= 4'd0;
      txd_q  <= 1'b1;
      txf_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      data_q <= data_nx;
      par_q  <= par_nx;
      div_q  <= div_nx;
      cnt_q  <= cnt_nx;
      txd_q  <= txd_nx;
      txf_q  <= txf_nx;
    end
  end

  always_comb begin
    state_nx = state;
    data_nx  = data_q;
    par_nx   = par_q;
    div_nx   = div_q;
    cnt_nx   = cnt_q;
    txd_nx   = txd_q;
    txf_nx   = 1'b0;

    if (state != IDLE) begin
      div_nx = bit_end ? 16'd0 : div_q + 16'd1;
    end

    // Each branch loads TXD with the value of the bit that the next state carries.
    case (state)
      IDLE: begin
        txd_nx = 1'b1;
        if (tx_load) begin
          state_nx = START;
          data_nx  = tx_data;
          par_nx   = (^tx_data) ^ PARITY_ODD;
          div_nx   = 16'd0;
          cnt_nx   = 4'd0;
          txd_nx   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nx = DATA;
          cnt_nx   = cnt_q + 4'd1;
          txd_nx   = data_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nx = cnt_q + 4'd1;
          if (cnt_q == LAST_DATA_IDX) begin
            state_nx = PARITY;
            txd_nx   = par_q;
          end else begin
            txd_nx = data_q[cnt_q[2:0]];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nx = STOP;
          cnt_nx   = cnt_q + 4'd1;
          txd_nx   = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nx = IDLE;
          cnt_nx   = 4'd0;
          txd_nx   = 1'b1;
          txf_nx   = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
        txd_nx   = 1'b1;
      end
    endcase
  end

  assign TXD           = txd_q;
  assign TXF           = txf_q;
  assign busy          = (state != IDLE);
  assign extra_counter = cnt_q;

endmodule
`default_nettype wire
